// File: rtl/ifq_pkg.sv
// Shared types and line geometry for the instruction fetch controller.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } fetch_state_t;

  localparam int unsigned LINE_BYTES     = 16;
  localparam int unsigned WORDS_PER_LINE = 4;

  // Words from a given word slot up to the end of its cache line (1..4).
  function automatic logic [2:0] words_left(input logic [1:0] word_idx);
    return 3'(WORDS_PER_LINE) - {1'b0, word_idx};
  endfunction

endpackage

// File: rtl/ifq_perf_cnt.sv
// Saturating 32-bit event counters for fetch performance monitoring.
// Counts lines pushed, redirects and q_free stall cycles; cleared by rst.
module ifq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_inc_i,
  input  logic        redirect_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] perf_lines_o,
  output logic [31:0] perf_redirects_o,
  output logic [31:0] perf_stall_cycles_o
);

  logic [31:0] lines_q, redirects_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lines_q     <= '0;
      redirects_q <= '0;
      stalls_q    <= '0;
    end else begin
      if (line_inc_i && (lines_q != '1))
        lines_q <= lines_q + 32'd1;
      if (redirect_inc_i && (redirects_q != '1))
        redirects_q <= redirects_q + 32'd1;
      if (stall_inc_i && (stalls_q != '1))
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_lines_o        = lines_q;
  assign perf_redirects_o    = redirects_q;
  assign perf_stall_cycles_o = stalls_q;

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Instruction fetch controller: whole-line cache requests into the instruction queue, with redirect/abort.
// Optional perf counters (lines, redirects, stall cycles) when IFQ_FETCH_PERF_EN is defined.
module ifq_fetch_ctrl
  import ifq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [31:0]                  pc_in,
  output logic                         cache_rd_en,
  output logic                         cache_abort,
  input  logic                         dout_valid,
  input  logic [$clog2(QUEUE_DEPTH):0] q_free,
  output logic                         q_push,
  output logic [2:0]                   q_push_count,
  output logic [1:0]                   q_offset,
  output logic                         q_flush,
  input  logic [31:0]                  jmp_branch_address,
  input  logic                         jmp_branch_valid,
`ifdef IFQ_FETCH_PERF_EN
  output logic [31:0]                  perf_lines,
  output logic [31:0]                  perf_redirects,
  output logic [31:0]                  perf_stall_cycles,
`endif
  output logic [31:0]                  pc_out
);

  fetch_state_t state_q;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         cache_rd_en_q, cache_abort_q;
  logic [31:0]  line_base;
  logic [2:0]   words_needed;
  logic         room_ok, issue_ok;

  assign line_base    = {fetch_pc_q[31:4], 4'b0000};
  assign words_needed = words_left(fetch_pc_q[3:2]);
  assign room_ok      = 32'(q_free) >= 32'(words_needed);
  assign issue_ok     = (state_q == IDLE) && !jmp_branch_valid && room_ok;

  // A redirect in the same cycle as the returning line wins; the line is dropped.
  assign q_push       = (state_q == WAIT) && dout_valid && !jmp_branch_valid && !rst;
  assign q_push_count = q_push ? words_needed : 3'd0;
  assign q_offset     = q_push ? fetch_pc_q[3:2] : 2'd0;
  assign q_flush      = jmp_branch_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (jmp_branch_valid)
      fetch_pc_d = jmp_branch_address & ~32'h3;
    else if (q_push)
      fetch_pc_d = line_base + 32'(LINE_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      cache_rd_en_q <= 1'b0;
      cache_abort_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      case (state_q)
        IDLE: begin
          if (issue_ok) begin
            state_q       <= WAIT;
            cache_rd_en_q <= 1'b1;
          end
        end
        WAIT: begin
          if (jmp_branch_valid) begin
            state_q       <= ABORT;
            cache_rd_en_q <= 1'b0;
            cache_abort_q <= 1'b1;
          end else if (dout_valid) begin
            state_q       <= IDLE;
            cache_rd_en_q <= 1'b0;
          end
        end
        ABORT: begin
          state_q       <= IDLE;
          cache_abort_q <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          cache_rd_en_q <= 1'b0;
          cache_abort_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_in       = line_base;
  assign pc_out      = fetch_pc_q;
  assign cache_rd_en = cache_rd_en_q;
  assign cache_abort = cache_abort_q;

`ifdef IFQ_FETCH_PERF_EN
  logic stall;
  assign stall = (state_q == IDLE) && !jmp_branch_valid && !room_ok;

  ifq_perf_cnt u_perf (
    .clk                 (clk),
    .rst                 (rst),
    .line_inc_i          (q_push),
    .redirect_inc_i      (jmp_branch_valid),
    .stall_inc_i         (stall),
    .perf_lines_o        (perf_lines),
    .perf_redirects_o    (perf_redirects),
    .perf_stall_cycles_o (perf_stall_cycles)
  );
`endif

endmodule

// File: doc/ifq_fetch_ctrl.md
IFQ_FETCH_CTRL -- requirements
Module: ifq_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 16, the instruction queue entry count.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port pc_in, output, 32, the line-aligned cache fetch address (bits [3:0] = 0).
REQ-006 The block SHALL have port cache_rd_en, output, 1, the cache read request.
REQ-007 The block SHALL have port cache_abort, output, 1, a one-cycle cancel of the outstanding request.
REQ-008 The block SHALL have port dout_valid, input, 1, indicating the cache line on dout is valid this cycle.
REQ-009 The block SHALL have port q_free, input, $clog2(QUEUE_DEPTH)+1, the free queue entries.
REQ-010 The block SHALL have port q_push, output, 1, a one-cycle queue write strobe.
REQ-011 The block SHALL have port q_push_count, output, 3, the words written on q_push (1..4).
REQ-012 The block SHALL have port q_offset, output, 2, the first valid word index within the line.
REQ-013 The block SHALL have port q_flush, output, 1, the queue flush.
REQ-014 The block SHALL have port jmp_branch_address, input, 32, the redirect target.
REQ-015 The block SHALL have port jmp_branch_valid, input, 1, the redirect strobe.
REQ-016 The block SHALL have port pc_out, output, 32, the current fetch PC (word-aligned).

Function
REQ-017 The block SHALL implement FSM states IDLE, WAIT, ABORT.
REQ-018 IDLE: when q_free >= 4 - fetch_pc[3:2] and no redirect, the block SHALL assert cache_rd_en with pc_in = {fetch_pc[31:4],4'b0} and move to WAIT next cycle.
REQ-019 WAIT: cache_rd_en and pc_in SHALL stay high/stable until dout_valid.
REQ-020 WAIT with dout_valid and no redirect: the block SHALL assert q_push same cycle, q_push_count = 4 - fetch_pc[3:2], q_offset = fetch_pc[3:2]; fetch_pc <= line base + 16 (32-bit wrap, 0xFFFF_FFF0 -> 0x0); return to IDLE.
REQ-021 Redirect in any state: q_flush = jmp_branch_valid combinationally; fetch_pc <= {jmp_branch_address[31:2],2'b00}.
REQ-022 Redirect in WAIT: the block SHALL go to ABORT; no q_push even if dout_valid the same cycle (redirect wins).
REQ-023 ABORT: the block SHALL hold cache_abort=1, cache_rd_en=0 for exactly one cycle, then go to IDLE.
REQ-024 dout_valid in IDLE or ABORT SHALL be ignored (no push).
REQ-025 Redirect in IDLE or ABORT SHALL only update fetch_pc; the state remains IDLE / proceeds to IDLE.
REQ-026 Insufficient q_free in IDLE SHALL stall with cache_rd_en=0; no partial-line fetch.
REQ-027 cache_abort and cache_rd_en SHALL never be high together.

Reset
REQ-028 On rst: state IDLE; fetch_pc = RESET_PC; cache_rd_en, cache_abort, q_push, q_push_count, q_offset = 0; q_flush = 0 unless jmp_branch_valid.
REQ-029 rst during WAIT SHALL drop cache_rd_en next cycle without asserting cache_abort; rst dominates redirect.

Configuration
REQ-030 With IFQ_FETCH_PERF_EN defined, the block SHALL add 32-bit outputs perf_lines, perf_redirects, perf_stall_cycles (lines pushed, redirects, IDLE cycles stalled on q_free), saturating, cleared by rst.
REQ-031 Without IFQ_FETCH_PERF_EN, these ports and counters SHALL be absent; other behaviour is identical.

Structure
REQ-032 Package ifq_pkg SHALL hold fetch_state_t (IDLE/WAIT/ABORT), LINE_BYTES=16, WORDS_PER_LINE=4.
REQ-033 The counters SHALL be one sub-module, ifq_perf_cnt, instantiated only under IFQ_FETCH_PERF_EN.

Verification
REQ-034 RESET_PC=0x100, q_free=16, dout_valid 2 cycles after request -> pc_in 0x100, push count 4 offset 0, then pc_in 0x110.
REQ-035 Redirect to 0x204 in IDLE -> q_flush same cycle; next request pc_in 0x200; push count 3, offset 1; next pc_in 0x210.
REQ-036 Redirect to 0x340 in WAIT, same cycle as dout_valid -> no q_push; cache_abort high 1 cycle; next request pc_in 0x340.
REQ-037 q_free=3, fetch_pc=0x100 -> cache_rd_en held 0; q_free=4 -> request issued next cycle.
REQ-038 fetch_pc=0xFFFF_FFF0, line returned -> next pc_in 0x0000_0000.
REQ-039 rst asserted in WAIT -> cache_rd_en 0 and cache_abort 0 next cycle; pc_out = RESET_PC; perf counters 0 (macro on).
